// File: rtl/shiftreg_serializer_8_if.sv
// ----------------------------------------------------------------------------
// shiftreg_serializer_8_if
// Parallel word handshake feeding the serializer's input FIFO.
//   in_valid     : producer has a word this cycle
//   in_ready     : serializer FIFO can take a word this cycle
//   in_data      : parallel word
//   in_msb_first : per-word bit order, travels with the word
// master = producer side, slave = serializer side.
// ----------------------------------------------------------------------------
interface shiftreg_serializer_8_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_msb_first;

    modport master (
        output in_valid,
        output in_data,
        output in_msb_first,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_msb_first,
        output in_ready
    );
endinterface

// File: rtl/shiftreg_serializer_8.sv
// ----------------------------------------------------------------------------
// shiftreg_serializer_8
// Parallel-to-serial output stage. Words arrive over a valid/ready handshake,
// are buffered in a small FIFO and leave one bit per clock, LSB- or MSB-first
// per word, framed by frame_start/frame_end, with GAP idle cycles between
// words.
//   clk         : rising-edge clock
//   clr         : asynchronous active-high reset
//   in_if       : input handshake (valid/ready/data/msb_first)
//   hold        : freezes the serial side; FIFO pushes still allowed
//   ser_out     : serial data bit
//   ser_valid   : ser_out carries a data bit
//   frame_start : first bit of a word
//   frame_end   : last bit of a word
//   busy        : FIFO non-empty or a word/gap in progress
//   fifo_count  : words currently buffered
// ----------------------------------------------------------------------------
module shiftreg_serializer_8 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                       clk,
    input  logic                       clr,
    shiftreg_serializer_8_if.slave     in_if,
    input  logic                       hold,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic                       frame_start,
    output logic                       frame_end,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;
    logic             msb_first;
    logic [BW-1:0]    bitcnt;
    logic [GW-1:0]    gapcnt;
    logic             push;
    logic             pop;
    logic [WIDTH:0]   head;

    // Ready depends only on the registered count, so a full FIFO refuses a
    // word even in a cycle where the serializer pops.
    assign in_if.in_ready = (count < CW'(DEPTH));
    assign push           = in_if.in_valid && in_if.in_ready;
    assign head           = mem[rd_ptr];
    assign fifo_count     = count;
    assign busy           = (state != S_IDLE) || (count != '0);

    // A pop happens whenever the serializer is ready to start a new word:
    // from IDLE, straight off the last bit when there is no gap, or at the
    // end of the gap.
    always_comb begin
        pop = 1'b0;
        if (!hold && count != '0) begin
            case (state)
                S_IDLE:  pop = 1'b1;
                S_SHIFT: pop = (bitcnt == '0) && (GAP == 0);
                S_GAP:   pop = (gapcnt == '0);
                default: pop = 1'b0;
            endcase
        end
    end

    // Word storage; the bit-order flag is kept as the top bit of each entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_if.in_msb_first, in_if.in_data};
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Serializer FSM. The shifter holds the bits not yet driven; bitcnt counts
    // how many of them remain after the bit currently on ser_out. hold simply
    // skips the whole update so every register keeps its value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= S_IDLE;
            shreg       <= '0;
            msb_first   <= 1'b0;
            bitcnt      <= '0;
            gapcnt      <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else if (!hold) begin
            if (pop) begin
                state       <= S_SHIFT;
                msb_first   <= head[WIDTH];
                bitcnt      <= BW'(WIDTH - 1);
                ser_valid   <= 1'b1;
                frame_start <= 1'b1;
                frame_end   <= 1'b0;
                if (head[WIDTH]) begin
                    ser_out <= head[WIDTH-1];
                    shreg   <= {head[WIDTH-2:0], 1'b0};
                end else begin
                    ser_out <= head[0];
                    shreg   <= {1'b0, head[WIDTH-1:1]};
                end
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (bitcnt != '0) begin
                            frame_start <= 1'b0;
                            frame_end   <= (bitcnt == BW'(1));
                            bitcnt      <= bitcnt - 1'b1;
                            if (msb_first) begin
                                ser_out <= shreg[WIDTH-1];
                                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                            end else begin
                                ser_out <= shreg[0];
                                shreg   <= {1'b0, shreg[WIDTH-1:1]};
                            end
                        end else begin
                            ser_out     <= 1'b0;
                            ser_valid   <= 1'b0;
                            frame_start <= 1'b0;
                            frame_end   <= 1'b0;
                            if (GAP > 0) begin
                                state  <= S_GAP;
                                gapcnt <= GW'((GAP > 0) ? GAP - 1 : 0);
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gapcnt != '0) begin
                            gapcnt <= gapcnt - 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_shiftreg_serializer_8.sv
// ----------------------------------------------------------------------------
// tb_shiftreg_serializer_8
// Directed self-checking bench. dut uses GAP=1, dut0 uses GAP=0 to cover
// back-to-back framing. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// ----------------------------------------------------------------------------
module tb_shiftreg_serializer_8;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       hold = 1'b0;
    logic       hold0 = 1'b0;
    logic       ser_out, ser_valid, frame_start, frame_end, busy;
    logic [2:0] fifo_count;
    logic       ser_out0, ser_valid0, frame_start0, frame_end0, busy0;
    logic [2:0] fifo_count0;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    shiftreg_serializer_8_if #(.WIDTH(8)) bus ();
    shiftreg_serializer_8_if #(.WIDTH(8)) bus0 ();

    shiftreg_serializer_8 #(.WIDTH(8), .DEPTH(4), .GAP(1)) dut (
        .clk(clk), .clr(clr), .in_if(bus), .hold(hold),
        .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
        .frame_end(frame_end), .busy(busy), .fifo_count(fifo_count)
    );

    shiftreg_serializer_8 #(.WIDTH(8), .DEPTH(4), .GAP(0)) dut0 (
        .clk(clk), .clr(clr), .in_if(bus0), .hold(hold0),
        .ser_out(ser_out0), .ser_valid(ser_valid0), .frame_start(frame_start0),
        .frame_end(frame_end0), .busy(busy0), .fifo_count(fifo_count0)
    );

    // Drives one word for exactly one accept edge on the GAP=1 instance.
    task automatic push1(input logic [7:0] d, input logic m);
        bus.in_valid     = 1'b1;
        bus.in_data      = d;
        bus.in_msb_first = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        repeat (2) @(posedge clk);
        #1;
        outs = {ser_out, ser_valid, frame_start, frame_end, busy};
        checks++;
        if (outs !== 5'b0) $display("[TB] FAIL reset_outputs: got %b expected %b", outs, 5'b0);
        else passes++;
        clr = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, fifo_count, busy} !== 5'b1_000_0)
            $display("[TB] FAIL reset_release: got %b expected %b", {bus.in_ready, fifo_count, busy}, 5'b1_000_0);
        else passes++;
        checks++;
        if ({bus0.in_ready, fifo_count0, busy0, ser_valid0} !== 6'b1_000_00)
            $display("[TB] FAIL reset_release_gap0: got %b expected %b", {bus0.in_ready, fifo_count0, busy0, ser_valid0}, 6'b1_000_00);
        else passes++;
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        logic [3:0] got, exp;
        w = 8'hA5;
        push1(w, 1'b0);
        checks++;
        if ({fifo_count, ser_valid} !== 4'b001_0)
            $display("[TB] FAIL lsb_latency: got %b expected %b", {fifo_count, ser_valid}, 4'b001_0);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            got = {ser_out, ser_valid, frame_start, frame_end};
            exp = {w[i], 1'b1, (i == 0), (i == 7)};
            checks++;
            if (got !== exp) $display("[TB] FAIL lsb_bit%0d: got %b expected %b", i, got, exp);
            else passes++;
        end
        @(posedge clk); #1;
        checks++;
        if ({ser_out, ser_valid, busy} !== 3'b001)
            $display("[TB] FAIL lsb_gap: got %b expected %b", {ser_out, ser_valid, busy}, 3'b001);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL lsb_busy_drop: got %b expected %b", busy, 1'b0);
        else passes++;
    endtask

    task automatic test_msb_first();
        logic [7:0] words [2];
        logic [7:0] w;
        logic [3:0] got, exp;
        words[0] = 8'hA5;
        words[1] = 8'h81;
        for (int k = 0; k < 2; k++) begin
            w = words[k];
            push1(w, 1'b1);
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                got = {ser_out, ser_valid, frame_start, frame_end};
                exp = {w[7-i], 1'b1, (i == 0), (i == 7)};
                checks++;
                if (got !== exp) $display("[TB] FAIL msb_w%0d_bit%0d: got %b expected %b", k, i, got, exp);
                else passes++;
            end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int         idx;
        logic       rdy;
        logic [7:0] q [$];
        hold = 1'b1;
        idx  = 0;
        bus.in_valid     = 1'b1;
        bus.in_msb_first = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.in_data = 8'(idx + 1);
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) idx++;
        end
        checks++;
        if ({idx[3:0], fifo_count, bus.in_ready, busy} !== 9'b0100_100_0_1)
            $display("[TB] FAIL full_stall: got %b expected %b", {idx[3:0], fifo_count, bus.in_ready, busy}, 9'b0100_100_0_1);
        else passes++;
        hold = 1'b0;
        fork
            begin
                for (int c = 0; c < 100 && idx < 6; c++) begin
                    bus.in_data = 8'(idx + 1);
                    rdy = bus.in_ready;
                    @(posedge clk); #1;
                    if (rdy) idx++;
                end
                bus.in_valid = 1'b0;
            end
            begin
                logic [7:0] cur;
                int         nb;
                cur = '0;
                nb  = 0;
                for (int c = 0; c < 150 && q.size() < 6; c++) begin
                    @(posedge clk); #1;
                    if (ser_valid) begin
                        cur[nb[2:0]] = ser_out;
                        nb++;
                        if (frame_end) begin
                            q.push_back(cur);
                            nb = 0;
                        end
                    end
                end
            end
        join
        checks++;
        if (q.size() !== 6) $display("[TB] FAIL bp_word_count: got %0d expected %0d", q.size(), 6);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            if (i < q.size()) begin
                checks++;
                if (q[i] !== 8'(i + 1)) $display("[TB] FAIL bp_word%0d: got %h expected %h", i, q[i], 8'(i + 1));
                else passes++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, fifo_count} !== 4'b0_000)
            $display("[TB] FAIL bp_drain: got %b expected %b", {busy, fifo_count}, 4'b0_000);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        logic [3:0] got, exp;
        int         j;
        bus0.in_valid     = 1'b1;
        bus0.in_data      = 8'h3C;
        bus0.in_msb_first = 1'b0;
        @(posedge clk); #1;
        bus0.in_data      = 8'hC5;
        bus0.in_msb_first = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            j = i % 8;
            if (i < 8) begin
                w = 8'h3C;
                exp = {w[j], 1'b1, (j == 0), (j == 7)};
            end else begin
                w = 8'hC5;
                exp = {w[7-j], 1'b1, (j == 0), (j == 7)};
            end
            got = {ser_out0, ser_valid0, frame_start0, frame_end0};
            checks++;
            if (got !== exp) $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", i, got, exp);
            else passes++;
        end
        @(posedge clk); #1;
        checks++;
        if ({ser_valid0, busy0} !== 2'b00)
            $display("[TB] FAIL b2b_end: got %b expected %b", {ser_valid0, busy0}, 2'b00);
        else passes++;
    endtask

    task automatic test_hold();
        logic [7:0] w;
        logic [3:0] got, exp;
        int         e;
        w = 8'hF0;
        push1(w, 1'b1);
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (c <= 3) e = c;
            else if (c <= 6) e = 3;
            else e = c - 3;
            got = {ser_out, ser_valid, frame_start, frame_end};
            exp = {w[7-e], 1'b1, (c == 0), (c == 10)};
            checks++;
            if (got !== exp) $display("[TB] FAIL hold_cycle%0d: got %b expected %b", c, got, exp);
            else passes++;
            hold = (c >= 3 && c <= 5);
        end
        hold = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ser_valid !== 1'b0) $display("[TB] FAIL hold_after: got %b expected %b", ser_valid, 1'b0);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        logic [7:0] w;
        logic [3:0] got, exp;
        logic [5:0] outs;
        int         seen;
        bus.in_valid     = 1'b1;
        bus.in_msb_first = 1'b0;
        bus.in_data      = 8'h11;
        @(posedge clk); #1;
        bus.in_data = 8'h22;
        @(posedge clk); #1;
        bus.in_data = 8'h33;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd2) $display("[TB] FAIL clr_queued: got %0d expected %0d", fifo_count, 2);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ser_out, ser_valid, frame_end} !== 3'b110)
            $display("[TB] FAIL clr_bit5: got %b expected %b", {ser_out, ser_valid, frame_end}, 3'b110);
        else passes++;
        #2 clr = 1'b1;
        #1;
        outs = {ser_out, ser_valid, frame_start, frame_end, busy, bus.in_ready};
        checks++;
        if ({outs, fifo_count} !== 9'b00000_1_000)
            $display("[TB] FAIL clr_async: got %b expected %b", {outs, fifo_count}, 9'b00000_1_000);
        else passes++;
        @(posedge clk); #1;
        clr = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ser_valid || frame_end || busy) seen++;
        end
        checks++;
        if (seen !== 0) $display("[TB] FAIL clr_quiet: got %0d active cycles expected %0d", seen, 0);
        else passes++;
        w = 8'h5A;
        push1(w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            got = {ser_out, ser_valid, frame_start, frame_end};
            exp = {w[i], 1'b1, (i == 0), (i == 7)};
            checks++;
            if (got !== exp) $display("[TB] FAIL clr_new_bit%0d: got %b expected %b", i, got, exp);
            else passes++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL clr_new_done: got %b expected %b", busy, 1'b0);
        else passes++;
    endtask

    // Runs every scenario in order, then prints the summary line.
    initial begin
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_msb_first  = 1'b0;
        bus0.in_valid     = 1'b0;
        bus0.in_data      = '0;
        bus0.in_msb_first = 1'b0;
        $display("[TB] start");
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_back_to_back();
        test_hold();
        test_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Bounds the whole run in case a scenario never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/shiftreg_serializer_8.md
Name: shiftreg_serializer_8

Overview:
- Parallel-to-serial output stage that sits directly downstream of the 8-bit universal shift register.
- Accepts parallel words (e.g. the register's q) over a valid/ready handshake and buffers them in a small FIFO.
- Emits each word one bit per clock, LSB-first or MSB-first per word, with frame markers and a programmable idle gap between words.
- Feeds serial links and test pins that cannot consume a parallel bus.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- DEPTH, 4, FIFO depth in words; power of two, ≥2.
- GAP, 1, idle cycles inserted between consecutive words (0 = back-to-back).

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- in_valid  in  1  in_data/in_msb_first valid this cycle.
- in_ready  out  1  FIFO can accept a word this cycle.
- in_data  in  WIDTH  parallel word.
- in_msb_first  in  1  1 = transmit bit WIDTH-1 first; 0 = bit 0 first; captured with the word.
- hold  in  1  freeze serial side (FIFO push still allowed).
- ser_out  out  1  serial data bit.
- ser_valid  out  1  ser_out carries a data bit.
- frame_start  out  1  first bit of a word on ser_out.
- frame_end  out  1  last bit of a word on ser_out.
- busy  out  1  FIFO non-empty or a word/gap in progress.
- fifo_count  out  $clog2(DEPTH+1)  words currently buffered.

Behaviour:
- Reset (clr=1, asynchronous): FIFO pointers and count cleared; state IDLE; ser_out, ser_valid, frame_start, frame_end, busy = 0; in_ready = 1 after release. A partial word is discarded and no frame_end is issued.
- Push: occurs when in_valid && in_ready at a clk edge and stores {in_msb_first, in_data}.
- in_ready = (fifo_count < DEPTH), combinational from the registered count. When full, in_ready = 0 even if a pop happens in the same cycle.
- Simultaneous push and pop (not full): count unchanged, both take effect.
- FSM states: IDLE, SHIFT, GAP. All serial outputs are registered.
- IDLE: if FIFO non-empty and hold = 0, pop at the edge and go to SHIFT.
  - Load the shifter with the word and bitcnt = WIDTH-1.
  - Drive the first bit (bit WIDTH-1 if msb_first, else bit 0) with ser_valid = 1 and frame_start = 1.
- Latency: word pushed at edge k into an empty FIFO, idle serializer → first bit visible after edge k+1.
- SHIFT, hold = 0: each edge shifts one bit toward the output and decrements bitcnt. frame_start = 0 after the first bit.
- SHIFT, last bit: when the driven bit is the last one (bitcnt = 0), frame_end = 1 for that cycle.
- On the edge leaving the last bit:
  - GAP > 0: go to GAP with gapcnt = GAP-1; ser_valid = 0, ser_out = 0.
  - GAP = 0 and FIFO non-empty: pop the next word immediately (frame_start on the next cycle, no idle cycle).
  - GAP = 0 and FIFO empty: go to IDLE.
- GAP: count down; at gapcnt = 0 behave as IDLE (pop if available, else go to IDLE).
- hold = 1: freezes shifter, bitcnt, gapcnt and state. ser_out, ser_valid, frame_start and frame_end keep their values. Pops are blocked. Pushes continue.
- Each word takes exactly WIDTH cycles of ser_valid with hold low.
- busy = (state != IDLE) || (fifo_count != 0).
- The FIFO pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH.

Test Plan:
- Reset, then push 8'hA5 with msb_first = 0, GAP = 1 → ser_out 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after the accept edge; frame_start on bit 1; frame_end on bit 8; then 1 cycle of ser_valid = 0 and busy drops.
- Push 8'hA5 with msb_first = 1 → ser_out 1,0,1,0,0,1,0,1 (MSB first, same pattern); then push 8'h81, msb_first = 1 → 1,0,0,0,0,0,0,1.
- Hold in_valid high with distinct words 8'h01..8'h06 while the serializer is stalled by hold = 1 → in_ready drops after 4 accepted, fifo_count = 4; release hold → words emerge in order 01,02,03,04, then 05,06 accepted as space frees; no loss or duplication.
- GAP = 0 build, two words queued → frame_end of word 1 immediately followed by frame_start of word 2; ser_valid stays high for 16 cycles.
- Assert hold for 3 cycles at bit 4 of 8'hF0 → ser_out and bitcnt frozen for 3 cycles; total frame spans 11 cycles; bit order intact.
- Assert clr at bit 5 of a word with 2 words queued → all outputs 0 immediately (asynchronously), fifo_count = 0, no frame_end; a new word after release transmits normally.
